rr_arbiter16: RTL and testbench
===============================

RR_ARBITER16 -- requirements
Module: rr_arbiter16

Interface
REQ-001 Parameter: TIMEOUT, 8'd200, max grant hold in cycles; 0 disables forced release.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: req  input  16  request vector; bit n = requester n.
REQ-005 Port: done  input  1  current owner releases resource (sampled only in GRANT).
REQ-006 Port: gnt  output  16  one-hot grant, registered; drives resource select.
REQ-007 Port: gnt_idx  output  4  binary index of owner, registered; feeds 4-to-16 select decoder.
REQ-008 Port: gnt_valid  output  1  registered; 1 while a grant is held.
REQ-009 Port: timeout_evt  output  1  one-cycle registered pulse on forced release.

Function
REQ-010 The block SHALL implement two states, IDLE and GRANT, plus an internal 4-bit priority pointer ptr and an 8-bit hold counter cnt.
REQ-011 In IDLE with req == 0, the block SHALL stay in IDLE and hold gnt = 0, gnt_valid = 0.
REQ-012 In IDLE with req != 0, the block SHALL select the first set bit scanning ptr, ptr+1, ... mod 16, and enter GRANT on the next edge.
REQ-013 On entering GRANT, the block SHALL set gnt_idx = winner, gnt = one-hot(winner), gnt_valid = 1 and cnt = 0 in the same edge, giving a latency of 1 cycle from req to grant.
REQ-014 In GRANT, gnt, gnt_idx and gnt_valid SHALL stay constant, and changes on other req bits SHALL have no effect.
REQ-015 In GRANT, the block SHALL release when done = 1, or when req[gnt_idx] = 0, or when TIMEOUT != 0 and cnt == TIMEOUT-1.
REQ-016 On release, the block SHALL return to IDLE on the next edge with gnt = 0, gnt_valid = 0 and ptr = gnt_idx+1 mod 16, so index 15 wraps to 0.
REQ-017 Release SHALL always leave one IDLE cycle with gnt_valid = 0 before the next grant, so back-to-back grants are never contiguous.
REQ-018 cnt SHALL increment by 1 per GRANT cycle, saturate at 8'hFF, and not increment in IDLE.
REQ-019 timeout_evt SHALL be 1 for exactly the cycle following a release caused only by timeout; if done or the req drop coincides with timeout, timeout_evt SHALL be 0.
REQ-020 The just-released requester SHALL have lowest priority in the next arbitration, which guarantees that any continuously asserting requester is granted within 16 grants.
REQ-021 gnt SHALL be all-zero or exactly one-hot in every cycle and SHALL always equal one-hot(gnt_idx) when gnt_valid = 1.
REQ-022 done asserted in IDLE SHALL be ignored.

Reset
REQ-023 rst = 1 SHALL immediately, without waiting for clk, force state = IDLE, ptr = 0, cnt = 0, gnt = 16'h0000, gnt_idx = 4'h0, gnt_valid = 0 and timeout_evt = 0.
REQ-024 Reset asserted mid-GRANT SHALL drop the grant asynchronously, and after deassertion arbitration SHALL restart from ptr = 0.
REQ-025 The first rising edge with rst = 0 SHALL be able to perform an arbitration.

Verification
REQ-026 Bench SHALL drive reset, then req = 16'h0040 -> one cycle later gnt = 16'h0040, gnt_idx = 4'h6, gnt_valid = 1; then done = 1 for 1 cycle -> gnt = 0 next cycle.
REQ-027 Bench SHALL hold req = 16'h8001 constant with done pulsed per grant -> grant order 0, 15, 0, 15, with one idle cycle between grants.
REQ-028 Bench SHALL cover wrap-around: grant idx 15 released, then req = 16'hFFFF -> next gnt_idx = 4'h0.
REQ-029 Bench SHALL use TIMEOUT = 4 with req = 16'h0008 held and done = 0 -> grant lasts exactly 4 cycles, then timeout_evt = 1 for 1 cycle and gnt_valid = 0 for 1 cycle, then regrant to idx 3.
REQ-030 Bench SHALL assert rst mid-GRANT (idx 9) -> gnt = 0 with no clk edge; after release with req = 16'h0201 -> gnt_idx = 4'h0.
REQ-031 Bench SHALL use a random req/done stream for at least 10k cycles, checking one-hot/consistency (REQ-021) and no starvation beyond 16 grants (REQ-020).

Source files
------------

// File: rtl/rr_arbiter16.sv
// rr_arbiter16: 16-way round-robin arbiter with done/drop release, hold timeout and a mandatory idle cycle between grants.
module rr_arbiter16 #(
  parameter logic [7:0] TIMEOUT = 8'd200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic        done,
  output logic [15:0] gnt,
  output logic [3:0]  gnt_idx,
  output logic        gnt_valid,
  output logic        timeout_evt
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t     state;
  logic [3:0] ptr;
  logic [3:0] off;
  logic [3:0] win;
  logic [7:0] cnt;
  logic       own_req;
  logic       to_hit;
  logic       rel;
  // Descending scan so the lowest offset from ptr wins.
  always_comb begin
    off = '0;
    for (int i = 15; i >= 0; i--)
      if (req[ptr + 4'(i)]) off = 4'(i);
  end
  assign win     = ptr + off;
  assign own_req = req[gnt_idx];
  assign to_hit  = (TIMEOUT != 8'd0) && (cnt == TIMEOUT - 8'd1);
  assign rel     = done || !own_req || to_hit;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      cnt         <= '0;
      gnt         <= '0;
      gnt_idx     <= '0;
      gnt_valid   <= 1'b0;
      timeout_evt <= 1'b0;
    end else if (state == IDLE) begin
      timeout_evt <= 1'b0;
      if (|req) begin
        state     <= GRANT;
        gnt_idx   <= win;
        gnt       <= 16'd1 << win;
        gnt_valid <= 1'b1;
        cnt       <= '0;
      end
    end else begin
      cnt         <= (cnt == 8'hFF) ? cnt : cnt + 8'd1;
      timeout_evt <= rel && to_hit && !done && own_req;
      if (rel) begin
        state     <= IDLE;
        gnt       <= '0;
        gnt_valid <= 1'b0;
        ptr       <= gnt_idx + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_rr_arbiter16.sv
// tb_rr_arbiter16: scoreboard bench for rr_arbiter16 (TIMEOUT=4) with directed scenarios and a random stream.
module tb_rr_arbiter16;
  localparam logic [7:0] TO = 8'd4;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] req = '0;
  logic        done = 1'b0;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_valid;
  logic        timeout_evt;
  int checks = 0;
  int failures = 0;
  typedef struct packed {
    logic [15:0] gnt;
    logic [3:0]  idx;
    logic        valid;
    logic        tevt;
  } exp_t;
  exp_t sb[$];
  logic       m_grant;
  logic [3:0] m_ptr;
  logic [3:0] m_idx;
  logic [7:0] m_cnt;
  logic       m_tevt;
  int         wait_n[16];
  int         max_wait = 0;
  logic       prev_valid = 1'b0;
  rr_arbiter16 #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout_evt(timeout_evt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_grant = 1'b0; m_ptr = '0; m_idx = '0; m_cnt = '0; m_tevt = 1'b0;
  endtask
  task automatic model_step(input logic [15:0] r, input logic d);
    logic hit;
    logic to_rel;
    if (!m_grant) begin
      m_tevt = 1'b0;
      hit = 1'b0;
      for (int k = 0; k < 16; k++) begin
        if (!hit && r[(int'(m_ptr) + k) % 16]) begin
          hit = 1'b1;
          m_idx = 4'((int'(m_ptr) + k) % 16);
        end
      end
      if (hit) begin
        m_grant = 1'b1;
        m_cnt = '0;
      end
    end else begin
      to_rel = (m_cnt == TO - 8'd1);
      m_tevt = 1'b0;
      if (d || !r[m_idx] || to_rel) begin
        m_tevt = to_rel && !d && r[m_idx];
        m_grant = 1'b0;
        m_ptr = m_idx + 4'd1;
      end
      if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    end
  endtask
  task automatic step(input logic [15:0] r, input logic d);
    exp_t e;
    @(negedge clk);
    req = r;
    done = d;
    model_step(r, d);
    e.valid = m_grant;
    e.idx = m_grant ? m_idx : 4'd0;
    e.gnt = m_grant ? (16'd1 << m_idx) : 16'd0;
    e.tevt = m_tevt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if ({gnt, gnt_valid, timeout_evt} !== {e.gnt, e.valid, e.tevt} || (e.valid && gnt_idx !== e.idx)) begin
      failures++;
      $display("FAIL sb got gnt=%h idx=%0d v=%b te=%b exp gnt=%h idx=%0d v=%b te=%b t=%0t",
               gnt, gnt_idx, gnt_valid, timeout_evt, e.gnt, e.idx, e.valid, e.tevt, $time);
    end
    chk("onehot", {31'd0, $onehot0(gnt) && (!gnt_valid || gnt == (16'd1 << gnt_idx))}, 32'd1);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    done = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    model_reset();
    #2;
    chk("rst_gnt", {16'd0, gnt}, 32'd0);
    chk("rst_idx", {28'd0, gnt_idx}, 32'd0);
    chk("rst_valid", {31'd0, gnt_valid}, 32'd0);
    chk("rst_tevt", {31'd0, timeout_evt}, 32'd0);
    do_reset();
    step(16'h0040, 1'b0);
    chk("b_gnt", {16'd0, gnt}, 32'h0040);
    chk("b_idx", {28'd0, gnt_idx}, 32'd6);
    chk("b_valid", {31'd0, gnt_valid}, 32'd1);
    step(16'h0040, 1'b1);
    chk("b_rel", {16'd0, gnt}, 32'd0);
    step(16'h0000, 1'b1);
    chk("idle_done", {31'd0, gnt_valid}, 32'd0);
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(16'h8001, 1'b0);
      chk("alt_idx", {28'd0, gnt_idx}, (k % 2 == 0) ? 32'd0 : 32'd15);
      chk("alt_valid", {31'd0, gnt_valid}, 32'd1);
      step(16'h8001, 1'b1);
      chk("alt_gap", {31'd0, gnt_valid}, 32'd0);
    end
    step(16'hFFFF, 1'b0);
    chk("wrap_idx", {28'd0, gnt_idx}, 32'd0);
    step(16'hFFFF, 1'b1);
    step(16'h0000, 1'b0);
    step(16'h0008, 1'b0);
    chk("to_idx", {28'd0, gnt_idx}, 32'd3);
    for (int k = 0; k < 3; k++) begin
      step(16'h0008, 1'b0);
      chk("to_hold", {31'd0, gnt_valid}, 32'd1);
      chk("to_noevt", {31'd0, timeout_evt}, 32'd0);
    end
    step(16'h0008, 1'b0);
    chk("to_rel", {31'd0, gnt_valid}, 32'd0);
    chk("to_evt", {31'd0, timeout_evt}, 32'd1);
    step(16'h0008, 1'b0);
    chk("to_regrant", {27'd0, gnt_valid, gnt_idx}, 32'h13);
    chk("to_evt_clr", {31'd0, timeout_evt}, 32'd0);
    step(16'h0008, 1'b1);
    do_reset();
    step(16'h0200, 1'b0);
    chk("ar_idx", {28'd0, gnt_idx}, 32'd9);
    @(posedge clk);
    #3;
    rst = 1'b1;
    req = '0;
    model_reset();
    #1;
    chk("ar_gnt", {16'd0, gnt}, 32'd0);
    chk("ar_valid", {31'd0, gnt_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(16'h0201, 1'b0);
    chk("ar_restart", {28'd0, gnt_idx}, 32'd0);
    for (int n = 0; n < 16; n++) wait_n[n] = 0;
    prev_valid = gnt_valid;
    for (int c = 0; c < 10000; c++) begin
      logic [15:0] r;
      r = req ^ (16'($urandom) & 16'($urandom) & 16'($urandom) & 16'($urandom));
      step(r, $urandom_range(0, 9) == 0);
      for (int n = 0; n < 16; n++) begin
        if (!r[n]) wait_n[n] = 0;
        else if (gnt_valid && !prev_valid) wait_n[n] = (gnt_idx == 4'(n)) ? 0 : wait_n[n] + 1;
        if (wait_n[n] > max_wait) max_wait = wait_n[n];
      end
      prev_valid = gnt_valid;
    end
    chk("starve", {31'd0, max_wait <= 16}, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
